// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed common-anode 7-segment scanner with double-buffered frame and per-slot blanking
module led_scan_ctrl #(
  parameter int N_DIGITS  = 8,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data,
  input  logic [N_DIGITS-1:0]     dp_mask,
  input  logic [N_DIGITS-1:0]     digit_en,
  output logic                    pending,
  output logic                    frame_done,
  output logic [N_DIGITS-1:0]     an,
  output logic [7:0]              seg
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, ns;
  logic [CW-1:0] cnt, ncnt;
  logic [IW-1:0] idx, nidx;
  logic [4*N_DIGITS-1:0] stg_data, sh_data;
  logic [N_DIGITS-1:0] stg_dp, stg_en, sh_dp, sh_en, an_n;
  logic [7:0] seg_n;
  logic wrap, upd, show, last;
  always_comb begin
    ns = state;
    ncnt = cnt;
    nidx = idx;
    wrap = 1'b0;
    last = cnt == CW'(DIV - 1);
    if (!en) begin
      ns = IDLE;
      ncnt = '0;
      nidx = '0;
    end else if (state == IDLE) begin
      ns = BLANK;
      ncnt = '0;
      nidx = '0;
    end else begin
      ncnt = last ? '0 : cnt + 1'b1;
      nidx = last ? ((idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1) : idx;
      wrap = last && idx == IW'(N_DIGITS - 1);
      ns = (ncnt < CW'(BLANK_CYC)) ? BLANK : SHOW;
    end
    upd = state == IDLE || wrap;
    // shadow only changes on edges entering BLANK/IDLE, so the current shadow is safe for the next SHOW
    show = ns == SHOW && sh_en[nidx];
    an_n = show ? ~(N_DIGITS'(1) << nidx) : '1;
    seg_n = show ? HEX[sh_data[{nidx, 2'b00} +: 4]] & {~sh_dp[nidx], 7'h7F} : 8'hFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      stg_data <= '0;
      stg_dp <= '0;
      stg_en <= '0;
      sh_data <= '0;
      sh_dp <= '0;
      sh_en <= '0;
      pending <= 1'b0;
      frame_done <= 1'b0;
      an <= '1;
      seg <= 8'hFF;
    end else begin
      state <= ns;
      cnt <= ncnt;
      idx <= nidx;
      an <= an_n;
      seg <= seg_n;
      frame_done <= wrap;
      if (load) begin
        stg_data <= data;
        stg_dp <= dp_mask;
        stg_en <= digit_en;
      end
      if (upd) begin
        sh_data <= load ? data : stg_data;
        sh_dp <= load ? dp_mask : stg_dp;
        sh_en <= load ? digit_en : stg_en;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: directed self-checking bench for led_scan_ctrl (4 digits, 8-cycle slots, 2-cycle blank)
module tb_led_scan_ctrl;
  logic clk = 0, rst, en, load, pending, frame_done;
  logic [15:0] data;
  logic [3:0] dp_mask, digit_en, an;
  logic [7:0] seg;
  logic [13:0] e;
  int total = 0, bad = 0;
  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  led_scan_ctrl #(.N_DIGITS(4), .DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .dp_mask(dp_mask),
    .digit_en(digit_en), .pending(pending), .frame_done(frame_done), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  // k is the cycle position inside a 32-cycle frame: slot k/8, phase k%8 (0..1 blank)
  function automatic logic [3:0] exp_an(int k, logic [3:0] den);
    int s;
    int c;
    s = k / 8;
    c = k % 8;
    return (c >= 2 && den[s]) ? ~(4'b0001 << s) : 4'hF;
  endfunction
  function automatic logic [7:0] exp_seg(int k, logic [15:0] d, logic [3:0] dp, logic [3:0] den);
    int s;
    int c;
    s = k / 8;
    c = k % 8;
    if (c < 2 || !den[s]) return 8'hFF;
    return HEX[d[4*s +: 4]] & {~dp[s], 7'h7F};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1; en = 0; load = 0; data = 0; dp_mask = 0; digit_en = 0;
    #1;
    tick;
    for (int i = 0; i < 50; i++) begin
      if (i == 2) rst = 0;
      total++;
      if ({an, seg, frame_done, pending} !== {4'hF, 8'hFF, 2'b00}) begin
        bad++;
        $display("FAIL reset i=%0d got=%h want=%h", i, {an, seg, frame_done, pending}, {4'hF, 8'hFF, 2'b00});
      end
      tick;
    end
  endtask
  task automatic test_basic_scan;
    data = 16'h3A70; dp_mask = 4'b0100; digit_en = 4'hF; load = 1;
    tick;
    load = 0;
    total++;
    if (pending !== 1'b0) begin
      bad++;
      $display("FAIL idle_load_pending got=%b want=0", pending);
    end
    en = 1;
    tick;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 32; k++) begin
        e = {exp_an(k, 4'hF), exp_seg(k, 16'h3A70, 4'b0100, 4'hF), k == 0 && f == 1, 1'b0};
        total++;
        if ({an, seg, frame_done, pending} !== e) begin
          bad++;
          $display("FAIL basic f=%0d k=%0d got=%h want=%h", f, k, {an, seg, frame_done, pending}, e);
        end
        tick;
      end
  endtask
  task automatic test_double_buffer;
    for (int k = 0; k < 32; k++) begin
      if (k == 12) load = 0;
      e = {exp_an(k, 4'hF), exp_seg(k, 16'h3A70, 4'b0100, 4'hF), k == 0, k >= 12};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL dbuf_old k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      if (k == 11) begin
        data = 16'h1111; dp_mask = 4'b0000; load = 1;
      end
      tick;
    end
    for (int k = 0; k < 32; k++) begin
      e = {exp_an(k, 4'hF), exp_seg(k, 16'h1111, 4'b0000, 4'hF), k == 0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL dbuf_new k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      tick;
    end
  endtask
  task automatic test_load_wrap;
    for (int k = 0; k < 32; k++) begin
      e = {exp_an(k, 4'hF), exp_seg(k, 16'h1111, 4'b0000, 4'hF), k == 0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL wrap_old k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      if (k == 31) begin
        data = 16'h4C2E; dp_mask = 4'b0001; load = 1;
      end
      tick;
    end
    for (int k = 0; k < 32; k++) begin
      if (k == 0) load = 0;
      e = {exp_an(k, 4'hF), exp_seg(k, 16'h4C2E, 4'b0001, 4'hF), k == 0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL wrap_new k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      tick;
    end
  endtask
  task automatic test_digit_mask;
    for (int k = 0; k < 32; k++) begin
      if (k == 1) load = 0;
      e = {exp_an(k, 4'hF), exp_seg(k, 16'h4C2E, 4'b0001, 4'hF), k == 0, k >= 1};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL mask_old k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      if (k == 0) begin
        digit_en = 4'b0101; load = 1;
      end
      tick;
    end
    for (int k = 0; k < 32; k++) begin
      e = {exp_an(k, 4'b0101), exp_seg(k, 16'h4C2E, 4'b0001, 4'b0101), k == 0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL mask_new k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      tick;
    end
  endtask
  task automatic test_disable;
    for (int k = 0; k < 20; k++) begin
      e = {exp_an(k, 4'b0101), exp_seg(k, 16'h4C2E, 4'b0001, 4'b0101), k == 0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL dis_pre k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      if (k == 19) en = 0;
      tick;
    end
    for (int j = 0; j < 40; j++) begin
      total++;
      if ({an, seg, frame_done, pending} !== {4'hF, 8'hFF, 2'b00}) begin
        bad++;
        $display("FAIL dis_dark j=%0d got=%h want=%h", j, {an, seg, frame_done, pending}, {4'hF, 8'hFF, 2'b00});
      end
      if (j == 39) en = 1;
      tick;
    end
    for (int k = 0; k < 32; k++) begin
      e = {exp_an(k, 4'b0101), exp_seg(k, 16'h4C2E, 4'b0001, 4'b0101), 1'b0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL dis_restart k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      tick;
    end
  endtask
  task automatic test_async_reset;
    for (int k = 0; k < 21; k++) begin
      e = {exp_an(k, 4'b0101), exp_seg(k, 16'h4C2E, 4'b0001, 4'b0101), k == 0, 1'b0};
      total++;
      if ({an, seg, frame_done, pending} !== e) begin
        bad++;
        $display("FAIL arst_pre k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, e);
      end
      if (k < 20) tick;
    end
    #2 rst = 1;
    #1;
    total++;
    if ({an, seg, frame_done, pending} !== {4'hF, 8'hFF, 2'b00}) begin
      bad++;
      $display("FAIL arst_now got=%h want=%h", {an, seg, frame_done, pending}, {4'hF, 8'hFF, 2'b00});
    end
    tick;
    rst = 0;
    tick;
    for (int k = 0; k < 32; k++) begin
      total++;
      if ({an, seg, frame_done, pending} !== {4'hF, 8'hFF, 2'b00}) begin
        bad++;
        $display("FAIL arst_post k=%0d got=%h want=%h", k, {an, seg, frame_done, pending}, {4'hF, 8'hFF, 2'b00});
      end
      tick;
    end
  endtask
  initial begin
    test_reset;
    test_basic_scan;
    test_double_buffer;
    test_load_wrap;
    test_digit_mask;
    test_disable;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode seven-segment digits.
- Holds a double-buffered hex frame and cycles the shared segment bus across the digits, one digit at a time.
- Inserts a blanking interval before each digit to prevent ghosting.
- Sits between the register/bus logic that supplies display values and the board-level anode and segment pins.

Parameters:
- N_DIGITS, 8, number of digits scanned (2..8).
- DIV, 50000, clock cycles per digit slot (BLANK plus SHOW); must be > BLANK_CYC.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  scan enable; 0 forces the display dark.
- load  input  1  one-cycle pulse; captures data, dp_mask and digit_en into staging.
- data  input  4*N_DIGITS  hex nibble per digit; digit i = data[4i+3:4i].
- dp_mask  input  N_DIGITS  1 = decimal point lit for that digit.
- digit_en  input  N_DIGITS  1 = digit displayed; 0 = digit kept dark during its slot.
- pending  output  1  staging holds a frame not yet shown.
- frame_done  output  1  one-cycle pulse at the end of each full scan.
- an  output  N_DIGITS  anode selects, active low, at most one bit low.
- seg  output  8  seg[7] = dp, seg[6:0] = g..a, all active low.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high. All outputs are registered.
- Reset values:
  - State IDLE, idx = 0, slot counter = 0.
  - Staging and shadow registers all 0, pending = 0.
  - an = all 1, seg = 8'hFF, frame_done = 0.
- Decode: common-anode hex code, reusing the team's led_anode decoder. Values 0..F map to C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E. When dp_mask[idx] = 1 for the shadow frame, seg[7] is cleared.
- States:
  - IDLE: an = all 1, seg = FF. If en = 1, the next cycle enters BLANK with idx = 0 and counter = 0.
  - BLANK: an = all 1, seg = FF for BLANK_CYC cycles, then SHOW.
  - SHOW:
    - If shadow digit_en[idx] = 1: an[idx] = 0 and seg = decode(shadow nibble idx).
    - Otherwise: an = all 1, seg = FF.
    - Lasts DIV - BLANK_CYC cycles, then BLANK with idx + 1.
- Wrap: after SHOW of idx = N_DIGITS-1, idx wraps to 0 and frame_done pulses high for exactly one cycle, coincident with the first BLANK cycle of the next frame.
- Frame period: exactly N_DIGITS*DIV cycles while en stays high.
- Load:
  - A load pulse copies the inputs into staging and sets pending = 1 on the next edge.
  - A load while pending = 1 overwrites staging; only the last load counts.
- Shadow update:
  - Staging is copied to shadow only at a frame boundary (the wrap edge), or on any edge while in IDLE. pending clears on the same edge.
  - The shadow never changes mid-frame (no tearing).
- Simultaneous load and boundary: the incoming load values go directly into shadow and pending stays 0.
- en falls mid-frame: the next edge enters IDLE, an = all 1, seg = FF, idx and counter reset to 0. No frame_done is issued. Shadow and pending are kept.
- rst asserted mid-operation: everything returns to the reset values immediately (asynchronous).

Test Plan:
- Bench parameters for all scenarios: N_DIGITS = 4, DIV = 8, BLANK_CYC = 2.
- Reset then idle: rst high, en = 0 → an = 4'hF, seg = 8'hFF, pending = 0 and frame_done = 0 for 50 cycles.
- Basic scan:
  - Stimulus: load data = 16'h3A70, dp_mask = 4'b0100, digit_en = 4'hF while idle, then en = 1.
  - Required per slot: 2 cycles with an = F, then 6 cycles per digit: an = E with seg = C0, an = D with seg = F8, an = B with seg = 08 (88 with dp cleared), an = 7 with seg = B0.
  - frame_done pulses every 32 cycles.
- Double buffer: mid-frame, load data = 16'h1111 → pending = 1; remaining digits still show the old frame; at the wrap edge shadow updates, pending = 0, and the next frame shows F9 on all digits.
- Load coincident with wrap: pulse load exactly on the wrap edge → the new value is displayed in the immediately following frame and pending never rises.
- Digit mask: digit_en = 4'b0101 → slots 1 and 3 keep an = F and seg = FF for the full 8 cycles; timing is unchanged.
- Disable and reset mid-frame:
  - Drop en during SHOW of digit 2 → next cycle an = F, seg = FF, no frame_done. Re-enable → scan restarts at digit 0 with BLANK.
  - Assert rst asynchronously mid-SHOW → outputs go to reset values before the next edge.
